// File: rtl/reg_writeback_if.sv
`timescale 1ns/1ps
// reg_writeback_if: bundle of every writeback-unit signal except Clk and reset.
//   Issue side : in_valid, inst, alu_result (to unit), in_ready (from unit)
//   Memory side: dmem_req, dmem_addr (from unit), dmem_ack, dmem_rdata (to unit)
//   Reg file   : busW, RegWr, Rw (from unit)
//   Status     : timeout_err, misalign_err (from unit)
// Modport slave is the writeback unit; modport master is its environment.
interface reg_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] alu_result;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] busW;
  logic        RegWr;
  logic [4:0]  Rw;
  logic        timeout_err;
  logic        misalign_err;

  modport slave (
    input  in_valid, inst, alu_result, dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_addr, busW, RegWr, Rw, timeout_err, misalign_err
  );

  modport master (
    output in_valid, inst, alu_result, dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_addr, busW, RegWr, Rw, timeout_err, misalign_err
  );
endinterface

// File: rtl/reg_writeback.sv
`timescale 1ns/1ps
// reg_writeback: RV32I writeback unit driving the register-file write port.
// Accepts one retiring instruction plus ALU result. Non-loads write alu_result.
// Loads read one word from data memory over a req/ack handshake, then extract
// and extend the byte/half/word. busW/RegWr/Rw are valid for exactly one cycle.
// Ports:
//   Clk    : system clock, posedge-sampled
//   reset  : asynchronous, active-high
//   wb     : reg_writeback_if.slave (issue, data-memory, reg-file, status)
// Parameter:
//   TIMEOUT_CYCLES : REQ cycles without dmem_ack before the load is abandoned (>=2)
// Build option:
//   WB_MISALIGN_TRAP_EN : trap misaligned LH/LHU/LW (no request, misalign_err pulse);
//                         undefined -> misalign_err stays 0, aligned-down extraction.
module reg_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          Clk,
  input  logic          reset,
  reg_writeback_if.slave wb
);

  localparam logic [6:0]  OPC_LOAD = 7'b0000011;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WRITE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       boff_q, boff_d;
  logic [31:0]      busW_q, busW_d;
  logic [31:0]      addr_q, addr_d;
  logic             regwr_q, regwr_d;
  logic             req_q, req_d;
  logic             to_q, to_d;
  logic             mis_q, mis_d;

  logic [6:0]  in_opc;
  logic [4:0]  in_rd;
  logic [2:0]  in_f3;
  logic        ld_illegal;
  logic        ld_misalign;
  logic        accept;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;
  logic        unused_inst_hi;

  assign in_opc = wb.inst[6:0];
  assign in_rd  = wb.inst[11:7];
  assign in_f3  = wb.inst[14:12];
  assign unused_inst_hi = ^wb.inst[31:15];

  assign ld_illegal = (in_f3 == 3'b011) || (in_f3 == 3'b110) || (in_f3 == 3'b111);

`ifdef WB_MISALIGN_TRAP_EN
  // f3[1:0]==01 covers LH and LHU; LW is exactly 010.
  assign ld_misalign = ((in_f3[1:0] == 2'b01) && wb.alu_result[0]) ||
                       ((in_f3 == 3'b010) && (wb.alu_result[1:0] != 2'b00));
`else
  assign ld_misalign = 1'b0;
`endif

  assign wb.in_ready = (state_q == S_IDLE) && !reset;
  assign accept      = wb.in_valid && wb.in_ready;

  // Lane select uses the latched address offset; halves look only at b[1].
  always_comb begin
    byte_sel = wb.dmem_rdata[{boff_q, 3'b000} +: 8];
    half_sel = boff_q[1] ? wb.dmem_rdata[31:16] : wb.dmem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext = {24'h000000, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext = {16'h0000, half_sel};
      default: ext = wb.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    boff_d  = boff_q;
    busW_d  = busW_q;
    addr_d  = addr_q;
    req_d   = req_q;
    regwr_d = 1'b0;
    to_d    = 1'b0;
    mis_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rd_d = in_rd;
          if (in_opc != OPC_LOAD) begin
            busW_d  = wb.alu_result;
            regwr_d = (in_rd != 5'd0);
            state_d = S_WRITE;
          end else if (ld_illegal) begin
            state_d = S_WRITE;
          end else if (ld_misalign) begin
            mis_d   = 1'b1;
            state_d = S_WRITE;
          end else begin
            f3_d    = in_f3;
            boff_d  = wb.alu_result[1:0];
            addr_d  = {wb.alu_result[31:2], 2'b00};
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        // Ack is tested before the timeout so an ack on the last cycle still writes.
        if (wb.dmem_ack) begin
          busW_d  = ext;
          regwr_d = (rd_q != 5'd0);
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_WRITE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WRITE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      boff_q  <= '0;
      busW_q  <= '0;
      addr_q  <= '0;
      regwr_q <= 1'b0;
      req_q   <= 1'b0;
      to_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      boff_q  <= boff_d;
      busW_q  <= busW_d;
      addr_q  <= addr_d;
      regwr_q <= regwr_d;
      req_q   <= req_d;
      to_q    <= to_d;
      mis_q   <= mis_d;
    end
  end

  assign wb.busW         = busW_q;
  assign wb.RegWr        = regwr_q;
  assign wb.Rw           = rd_q;
  assign wb.dmem_req     = req_q;
  assign wb.dmem_addr    = addr_q;
  assign wb.timeout_err  = to_q;
  assign wb.misalign_err = mis_q;

endmodule

// File: tb/tb_reg_writeback.sv
`timescale 1ns/1ps
module tb_reg_writeback;

  localparam int unsigned TO = 16;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  reg_writeback_if bus();

  reg_writeback #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk   (Clk),
    .reset (reset),
    .wb    (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd);
    logic [16:0] hi;
    hi = 17'($urandom());
    return {hi, f3, rd, opc};
  endfunction

  // Reference load extraction using shifts and masks on the whole word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] b,
                                           input logic [31:0] w);
    logic [31:0] v;
    int unsigned sh;
    case (f3)
      3'd0, 3'd4: begin
        sh = 8 * int'(b);
        v  = (w >> sh) & 32'h0000_00FF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        sh = (b >= 2'd2) ? 16 : 0;
        v  = (w >> sh) & 32'h0000_FFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // One instruction: model predicts the outcome, bench plays data memory acking
  // on the ack_at-th REQ cycle (values above TO never ack).
  task automatic run_txn(input string name, input logic [31:0] inst,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input int unsigned ack_at);
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          is_load, bad_f3, mis;
    int unsigned exp_req, exp_end, exp_wr, exp_to, exp_mis, exp_wcyc;
    logic [31:0] exp_bus;
    int unsigned w, cyc, reqs, wr_cnt, to_cnt, mis_cnt, wr_cyc;
    logic [31:0] got_bus, got_addr;
    logic [4:0]  got_rw;
    bit          done;

    f3      = inst[14:12];
    rd      = inst[11:7];
    is_load = (inst[6:0] == 7'b0000011);
    bad_f3  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    mis     = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (alu % 2 != 0)) mis = 1'b1;
    if (f3 == 3'd2 && (alu % 4 != 0)) mis = 1'b1;
`endif
    exp_req = 0; exp_wr = 0; exp_to = 0; exp_mis = 0; exp_wcyc = 1;
    exp_end = 2; exp_bus = alu;
    if (!is_load) begin
      exp_wr = (rd != 0) ? 1 : 0;
    end else if (bad_f3) begin
      exp_wr = 0;
    end else if (mis) begin
      exp_mis = 1;
    end else if (ack_at <= TO) begin
      exp_req  = ack_at;
      exp_wr   = (rd != 0) ? 1 : 0;
      exp_wcyc = ack_at + 1;
      exp_end  = ack_at + 2;
      exp_bus  = ref_load(f3, alu[1:0], rdata);
    end else begin
      exp_req = TO;
      exp_to  = 1;
      exp_end = TO + 1;
    end

    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge Clk);
      w++;
    end
    check_eq({name, "/ready"}, {31'b0, bus.in_ready}, 32'd1);
    if (!bus.in_ready) return;

    bus.in_valid   = 1'b1;
    bus.inst       = inst;
    bus.alu_result = alu;

    cyc = 0; reqs = 0; wr_cnt = 0; to_cnt = 0; mis_cnt = 0; wr_cyc = 0;
    got_bus = '0; got_addr = '0; got_rw = '0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) bus.in_valid = 1'b0;
      if (bus.RegWr) begin
        wr_cnt++;
        wr_cyc  = cyc;
        got_bus = bus.busW;
        got_rw  = bus.Rw;
      end
      if (bus.timeout_err)  to_cnt++;
      if (bus.misalign_err) mis_cnt++;
      if (bus.dmem_req) begin
        reqs++;
        if (reqs == 1) got_addr = bus.dmem_addr;
        bus.dmem_ack   = (reqs == ack_at);
        bus.dmem_rdata = bus.dmem_ack ? rdata : $urandom();
      end else begin
        bus.dmem_ack   = ($urandom_range(0, 3) == 0);
        bus.dmem_rdata = $urandom();
      end
      if (bus.in_ready && cyc > 0) done = 1'b1;
    end
    bus.dmem_ack = 1'b0;

    check_eq({name, "/done"},     {31'b0, done}, 32'd1);
    check_eq({name, "/end_cyc"},  cyc,     exp_end);
    check_eq({name, "/req_cyc"},  reqs,    exp_req);
    check_eq({name, "/wr_count"}, wr_cnt,  exp_wr);
    check_eq({name, "/timeout"},  to_cnt,  exp_to);
    check_eq({name, "/misalign"}, mis_cnt, exp_mis);
    if (exp_req > 0)
      check_eq({name, "/addr"}, got_addr, {alu[31:2], 2'b00});
    if (exp_wr > 0) begin
      check_eq({name, "/busW"},   got_bus, exp_bus);
      check_eq({name, "/Rw"},     {27'b0, got_rw}, {27'b0, rd});
      check_eq({name, "/wr_cyc"}, wr_cyc, exp_wcyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "/busW"},     bus.busW, 32'd0);
    check_eq({tag, "/RegWr"},    {31'b0, bus.RegWr}, 32'd0);
    check_eq({tag, "/Rw"},       {27'b0, bus.Rw}, 32'd0);
    check_eq({tag, "/dmem_req"}, {31'b0, bus.dmem_req}, 32'd0);
    check_eq({tag, "/addr"},     bus.dmem_addr, 32'd0);
    check_eq({tag, "/to_err"},   {31'b0, bus.timeout_err}, 32'd0);
    check_eq({tag, "/mis_err"},  {31'b0, bus.misalign_err}, 32'd0);
    check_eq({tag, "/in_ready"}, {31'b0, bus.in_ready}, 32'd0);
  endtask

  // Reset in the middle of REQ: request drops at once, late ack never writes.
  task automatic reset_mid_load();
    int unsigned wr_cnt, req_cnt;
    @(negedge Clk);
    bus.in_valid   = 1'b1;
    bus.inst       = mk_inst(7'b0000011, 3'd2, 5'd12);
    bus.alu_result = 32'h0000_0400;
    @(negedge Clk);
    bus.in_valid = 1'b0;
    check_eq("rst_mid/req_before", {31'b0, bus.dmem_req}, 32'd1);
    repeat (2) @(negedge Clk);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge Clk);
    reset = 1'b0;
    wr_cnt = 0; req_cnt = 0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (bus.RegWr)    wr_cnt++;
      if (bus.dmem_req) req_cnt++;
    end
    bus.dmem_ack = 1'b0;
    check_eq("rst_mid/late_wr",  wr_cnt,  32'd0);
    check_eq("rst_mid/late_req", req_cnt, 32'd0);
    check_eq("rst_mid/ready",    {31'b0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] w;

    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.inst       = '0;
    bus.alu_result = '0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    repeat (2) @(negedge Clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge Clk);

    run_txn("addi",      mk_inst(7'b0010011, 3'd0, 5'd5), 32'h0000_1234, 32'h0, 1);
    run_txn("lb",        mk_inst(7'b0000011, 3'd0, 5'd3), 32'h0000_0103, 32'h8012_3456, 2);
    run_txn("lbu",       mk_inst(7'b0000011, 3'd4, 5'd3), 32'h0000_0103, 32'h8012_3456, 2);
    run_txn("lh",        mk_inst(7'b0000011, 3'd1, 5'd7), 32'h0000_0202, 32'h8001_1234, 1);
    run_txn("lhu",       mk_inst(7'b0000011, 3'd5, 5'd7), 32'h0000_0202, 32'h8001_1234, 3);
    run_txn("lw_rd0",    mk_inst(7'b0000011, 3'd2, 5'd0), 32'h0000_0300, 32'hCAFE_F00D, 1);
    run_txn("lw_tmo",    mk_inst(7'b0000011, 3'd2, 5'd4), 32'h0000_0500, 32'h1111_2222, 99);
    run_txn("lw_ack16",  mk_inst(7'b0000011, 3'd2, 5'd6), 32'h0000_0504, 32'h3333_4444, TO);
    run_txn("lw_mis",    mk_inst(7'b0000011, 3'd2, 5'd9), 32'h0000_0101, 32'hA5A5_5A5A, 1);
    run_txn("ld_illeg",  mk_inst(7'b0000011, 3'd3, 5'd8), 32'h0000_0600, 32'h0, 1);
    run_txn("alu_rd0",   mk_inst(7'b0110011, 3'd0, 5'd0), 32'h7777_7777, 32'h0, 1);

    reset_mid_load();

    for (int n = 0; n < 150; n++) begin
      opc = 7'($urandom());
      if ($urandom_range(0, 1) == 1) opc = 7'b0000011;
      else if (opc == 7'b0000011) opc = 7'b0010011;
      f3  = 3'($urandom());
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom());
      alu = $urandom();
      w   = $urandom();
      run_txn("rand", mk_inst(opc, f3, rd), alu, w, $urandom_range(1, TO + 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
